sram_axi_bridge: RTL and testbench

//  Converts the core's two SRAM-like ports (inst, data: req/addr_ok/data_ok) into a single AXI3/4 master.

---
 rtl/sram_axi_bridge_pkg.sv | 30 +++
 rtl/sram_axi_bridge_if.sv | 71 +++++++
 rtl/sram_axi_bridge_wr_ctrl.sv | 90 +++++++++
 rtl/sram_axi_bridge.sv | 168 ++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the SRAM-to-AXI bridge: transaction IDs, FSM encodings
// and the fixed AXI attribute values driven on every transfer.
package sram_axi_bridge_pkg;

  localparam logic [3:0] INST_ID_DEF = 4'd0;
  localparam logic [3:0] DATA_ID_DEF = 4'd1;

  localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEV   = 4'b0000;
  localparam logic [2:0] AXI_PROT_DEF    = 3'b000;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_e;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_SEND   = 2'd1,
    W_WAIT_B = 2'd2
  } w_state_e;

  // SRAM size code (0/1/2 = byte/half/word) maps directly onto AXI axsize.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// AXI3/4 channel bundle between the bridge (master) and the SoC interconnect (slave).
interface sram_axi_bridge_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/sram_axi_bridge_wr_ctrl.sv
// Write path of the bridge: latches one data-port store and drives it out on AW/W,
// then waits for the B response.
//
//  state    | meaning
//  W_IDLE   | no store in flight, ready to accept one
//  W_SEND   | AW and/or W still waiting for their ready
//  W_WAIT_B | address and data both handed off, waiting for bvalid
module sram_axi_bridge_wr_ctrl
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic        awready,
  input  logic        wready,
  input  logic        bvalid,
  output logic        awvalid,
  output logic        wvalid,
  output logic [31:0] aw_addr,
  output logic [2:0]  aw_size,
  output logic [3:0]  w_strb,
  output logic [31:0] w_data,
  output logic        idle,
  output logic        done
);

  w_state_e state, state_nxt;
  logic     aw_pend, aw_pend_nxt;
  logic     w_pend, w_pend_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= W_IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      aw_addr <= '0;
      aw_size <= '0;
      w_strb  <= '0;
      w_data  <= '0;
    end else begin
      state   <= state_nxt;
      aw_pend <= aw_pend_nxt;
      w_pend  <= w_pend_nxt;
      if (start && state == W_IDLE) begin
        aw_addr <= addr;
        aw_size <= axi_size(size);
        w_strb  <= wstrb;
        w_data  <= wdata;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    aw_pend_nxt = aw_pend;
    w_pend_nxt  = w_pend;
    done        = 1'b0;
    unique case (state)
      W_IDLE: begin
        if (start) begin
          state_nxt   = W_SEND;
          aw_pend_nxt = 1'b1;
          w_pend_nxt  = 1'b1;
        end
      end
      W_SEND: begin
        // AW and W retire independently; move on once neither is left.
        if (awready) aw_pend_nxt = 1'b0;
        if (wready)  w_pend_nxt  = 1'b0;
        if (!aw_pend_nxt && !w_pend_nxt) state_nxt = W_WAIT_B;
      end
      W_WAIT_B: begin
        if (bvalid) begin
          done      = 1'b1;
          state_nxt = W_IDLE;
        end
      end
      default: state_nxt = W_IDLE;
    endcase
  end

  assign awvalid = (state == W_SEND) && aw_pend;
  assign wvalid  = (state == W_SEND) && w_pend;
  assign idle    = (state == W_IDLE);

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst and data SRAM-like ports onto one AXI master; single-beat,
// one outstanding transaction per port, R beats routed back by rid.
//
//  state   | meaning
//  AR_IDLE | no read address pending, a new read may be accepted
//  AR_BUSY | arvalid held with latched id/addr/size until arready
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  sram_axi_bridge_if.master axi
);

  ar_state_e   ar_state, ar_state_nxt;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [2:0]  ar_size;
  logic        inst_pend;
  logic        data_rd_pend;

  logic        rd_data_go;
  logic        rd_inst_go;
  logic        wr_go;
  logic        inst_r_hit;
  logic        data_r_hit;

  logic        wr_idle;
  logic        wr_done;
  logic        wr_awvalid;
  logic        wr_wvalid;
  logic [31:0] wr_awaddr;
  logic [2:0]  wr_awsize;
  logic [3:0]  wr_wstrb;
  logic [31:0] wr_wdata;

  // Data reads win the AR slot over inst reads; the data port is idle only when
  // neither a read nor a write of its own is still in flight.
  always_comb begin
    rd_data_go = data_sram_req && !data_sram_wr && (ar_state == AR_IDLE)
                 && !data_rd_pend && wr_idle;
    rd_inst_go = inst_sram_req && (ar_state == AR_IDLE) && !inst_pend && !rd_data_go;
    wr_go      = data_sram_req && data_sram_wr && wr_idle && !data_rd_pend;
    inst_r_hit = axi.rvalid && (axi.rid == INST_ID) && inst_pend;
    data_r_hit = axi.rvalid && (axi.rid == DATA_ID) && data_rd_pend;
  end

  always_comb begin
    ar_state_nxt = ar_state;
    unique case (ar_state)
      AR_IDLE: if (rd_data_go || rd_inst_go) ar_state_nxt = AR_BUSY;
      AR_BUSY: if (axi.arready)              ar_state_nxt = AR_IDLE;
      default: ar_state_nxt = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_state     <= AR_IDLE;
      ar_id        <= '0;
      ar_addr      <= '0;
      ar_size      <= '0;
      inst_pend    <= 1'b0;
      data_rd_pend <= 1'b0;
    end else begin
      ar_state <= ar_state_nxt;
      if (rd_data_go) begin
        ar_id   <= DATA_ID;
        ar_addr <= data_sram_addr;
        ar_size <= axi_size(data_sram_size);
      end else if (rd_inst_go) begin
        ar_id   <= INST_ID;
        ar_addr <= inst_sram_addr;
        ar_size <= axi_size(inst_sram_size);
      end
      if (rd_inst_go)      inst_pend <= 1'b1;
      else if (inst_r_hit) inst_pend <= 1'b0;
      if (rd_data_go)      data_rd_pend <= 1'b1;
      else if (data_r_hit) data_rd_pend <= 1'b0;
    end
  end

  sram_axi_bridge_wr_ctrl u_wr_ctrl (
    .clk     (clk),
    .resetn  (resetn),
    .start   (wr_go),
    .addr    (data_sram_addr),
    .size    (data_sram_size),
    .wstrb   (data_sram_wstrb),
    .wdata   (data_sram_wdata),
    .awready (axi.awready),
    .wready  (axi.wready),
    .bvalid  (axi.bvalid),
    .awvalid (wr_awvalid),
    .wvalid  (wr_wvalid),
    .aw_addr (wr_awaddr),
    .aw_size (wr_awsize),
    .w_strb  (wr_wstrb),
    .w_data  (wr_wdata),
    .idle    (wr_idle),
    .done    (wr_done)
  );

  assign inst_sram_addr_ok = rd_inst_go;
  assign inst_sram_data_ok = inst_r_hit;
  assign inst_sram_rdata   = axi.rdata;
  assign data_sram_addr_ok = rd_data_go || wr_go;
  assign data_sram_data_ok = data_r_hit || wr_done;
  assign data_sram_rdata   = axi.rdata;

  assign axi.arid    = ar_id;
  assign axi.araddr  = ar_addr;
  assign axi.arlen   = AXI_LEN_SINGLE;
  assign axi.arsize  = ar_size;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arlock  = AXI_LOCK_NORMAL;
  assign axi.arcache = AXI_CACHE_DEV;
  assign axi.arprot  = AXI_PROT_DEF;
  assign axi.arvalid = (ar_state == AR_BUSY);
  assign axi.rready  = 1'b1;

  assign axi.awid    = DATA_ID;
  assign axi.awaddr  = wr_awaddr;
  assign axi.awlen   = AXI_LEN_SINGLE;
  assign axi.awsize  = wr_awsize;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awlock  = AXI_LOCK_NORMAL;
  assign axi.awcache = AXI_CACHE_DEV;
  assign axi.awprot  = AXI_PROT_DEF;
  assign axi.awvalid = wr_awvalid;

  assign axi.wid     = DATA_ID;
  assign axi.wdata   = wr_wdata;
  assign axi.wstrb   = wr_wstrb;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wr_wvalid;
  assign axi.bready  = 1'b1;

  // Inst port is read-only and responses are always treated as OKAY.
  logic unused_ok;
  assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                       axi.rresp, axi.rlast, axi.bid, axi.bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: a table of single transactions plus
// hand-written sequences for arbitration, split AW/W, write blocking and reset.
module tb_sram_axi_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  sram_axi_bridge_if axi ();

  sram_axi_bridge dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .axi               (axi.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // kind: 0 none, 1 inst read, 2 data read, 3 data write
  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        dwr;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        e_iok;
    logic        e_dok;
    int          kind;
    logic [3:0]  e_id;
    logic [31:0] e_addr;
    logic [2:0]  e_size;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h1c000000, 32'h0, 2'd2, 4'h0, 32'h0, 32'h02800404,
                1'b1, 1'b0, 1, 4'd0, 32'h1c000000, 3'd2};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h80001000, 2'd0, 4'h0, 32'h0, 32'hcafe0011,
                1'b0, 1'b1, 2, 4'd1, 32'h80001000, 3'd0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h1c000004, 32'h00002000, 2'd1, 4'h0, 32'h0, 32'h0000beef,
                1'b0, 1'b1, 2, 4'd1, 32'h00002000, 3'd1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h00001000, 2'd0, 4'b0010, 32'h0000ab00, 32'h0,
                1'b0, 1'b1, 3, 4'd1, 32'h00001000, 3'd0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 4'h0, 32'h0, 32'h0,
                1'b0, 1'b0, 0, 4'd0, 32'h0, 3'd0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h00003004, 2'd2, 4'hf, 32'hdeadbeef, 32'h0,
                1'b0, 1'b1, 3, 4'd1, 32'h00003004, 3'd2};
  end

  initial begin
    resetn = 1'b0;
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
    inst_sram_wstrb = 4'h0; inst_sram_addr = '0; inst_sram_wdata = '0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2;
    data_sram_wstrb = 4'h0; data_sram_addr = '0; data_sram_wdata = '0;
    axi.arready = 1'b0; axi.rid = 4'd0; axi.rdata = '0; axi.rresp = 2'd0;
    axi.rlast = 1'b1; axi.rvalid = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bid = 4'd1; axi.bresp = 2'd0; axi.bvalid = 1'b0;

    smp();
    chk1("rst_arvalid", axi.arvalid, 1'b0);
    chk1("rst_awvalid", axi.awvalid, 1'b0);
    chk1("rst_wvalid", axi.wvalid, 1'b0);
    chk32("rst_araddr", axi.araddr, 32'h0);
    drv_edge();
    drv_edge();
    resetn = 1'b1;
    smp();
    chk1("idle_inst_addr_ok", inst_sram_addr_ok, 1'b0);
    chk1("idle_data_addr_ok", data_sram_addr_ok, 1'b0);
    chk1("idle_inst_data_ok", inst_sram_data_ok, 1'b0);
    chk1("idle_data_data_ok", data_sram_data_ok, 1'b0);
    chk1("const_rready", axi.rready, 1'b1);
    chk1("const_bready", axi.bready, 1'b1);
    chk1("const_wlast", axi.wlast, 1'b1);
    chk32("const_arlen", 32'(axi.arlen), 32'h0);
    chk32("const_arburst", 32'(axi.arburst), 32'h1);
    chk32("const_awburst", 32'(axi.awburst), 32'h1);

    // Table: one transaction per record, always ending back in idle.
    for (int i = 0; i < NV; i++) begin
      drv_edge();
      inst_sram_req  = vecs[i].ireq;  inst_sram_addr = vecs[i].iaddr;
      inst_sram_size = vecs[i].size;
      data_sram_req  = vecs[i].dreq;  data_sram_wr   = vecs[i].dwr;
      data_sram_addr = vecs[i].daddr; data_sram_size = vecs[i].size;
      data_sram_wstrb = vecs[i].wstrb; data_sram_wdata = vecs[i].wdata;
      smp();
      chk1($sformatf("v%0d_inst_addr_ok", i), inst_sram_addr_ok, vecs[i].e_iok);
      chk1($sformatf("v%0d_data_addr_ok", i), data_sram_addr_ok, vecs[i].e_dok);
      drv_edge();
      inst_sram_req = 1'b0; data_sram_req = 1'b0;
      smp();
      if (vecs[i].kind == 1 || vecs[i].kind == 2) begin
        chk1($sformatf("v%0d_arvalid", i), axi.arvalid, 1'b1);
        chk32($sformatf("v%0d_arid", i), 32'(axi.arid), 32'(vecs[i].e_id));
        chk32($sformatf("v%0d_araddr", i), axi.araddr, vecs[i].e_addr);
        chk32($sformatf("v%0d_arsize", i), 32'(axi.arsize), 32'(vecs[i].e_size));
        axi.arready = 1'b1;
      end else if (vecs[i].kind == 3) begin
        chk1($sformatf("v%0d_awvalid", i), axi.awvalid, 1'b1);
        chk1($sformatf("v%0d_wvalid", i), axi.wvalid, 1'b1);
        chk32($sformatf("v%0d_awaddr", i), axi.awaddr, vecs[i].e_addr);
        chk32($sformatf("v%0d_awsize", i), 32'(axi.awsize), 32'(vecs[i].e_size));
        chk32($sformatf("v%0d_wstrb", i), 32'(axi.wstrb), 32'(vecs[i].wstrb));
        chk32($sformatf("v%0d_wdata", i), axi.wdata, vecs[i].wdata);
        chk32($sformatf("v%0d_awid", i), 32'(axi.awid), 32'h1);
        axi.awready = 1'b1; axi.wready = 1'b1;
      end else begin
        chk1($sformatf("v%0d_no_arvalid", i), axi.arvalid, 1'b0);
        chk1($sformatf("v%0d_no_awvalid", i), axi.awvalid, 1'b0);
      end
      drv_edge();
      axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
      if (vecs[i].kind == 1 || vecs[i].kind == 2) begin
        axi.rvalid = 1'b1; axi.rid = vecs[i].e_id; axi.rdata = vecs[i].rdata;
      end else if (vecs[i].kind == 3) begin
        axi.bvalid = 1'b1;
      end
      smp();
      chk1($sformatf("v%0d_arvalid_done", i), axi.arvalid, 1'b0);
      chk1($sformatf("v%0d_awvalid_done", i), axi.awvalid, 1'b0);
      chk1($sformatf("v%0d_inst_data_ok", i), inst_sram_data_ok, vecs[i].kind == 1);
      chk1($sformatf("v%0d_data_data_ok", i), data_sram_data_ok, vecs[i].kind >= 2);
      if (vecs[i].kind == 1)
        chk32($sformatf("v%0d_inst_rdata", i), inst_sram_rdata, vecs[i].rdata);
      if (vecs[i].kind == 2)
        chk32($sformatf("v%0d_data_rdata", i), data_sram_rdata, vecs[i].rdata);
      drv_edge();
      axi.rvalid = 1'b0; axi.bvalid = 1'b0;
    end

    // Arbitration with inst retry, then out-of-order R routed by rid.
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000010; inst_sram_size = 2'd2;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h40; data_sram_size = 2'd2;
    smp();
    chk1("arb_data_first", data_sram_addr_ok, 1'b1);
    chk1("arb_inst_loses", inst_sram_addr_ok, 1'b0);
    drv_edge();
    data_sram_req = 1'b0;
    smp();
    chk32("arb_arid_data", 32'(axi.arid), 32'h1);
    chk1("arb_inst_wait_ar", inst_sram_addr_ok, 1'b0);
    axi.arready = 1'b1;
    drv_edge();
    axi.arready = 1'b0;
    smp();
    chk1("arb_inst_retry_ok", inst_sram_addr_ok, 1'b1);
    drv_edge();
    inst_sram_req = 1'b0;
    smp();
    chk32("arb_arid_inst", 32'(axi.arid), 32'h0);
    chk32("arb_araddr_inst", axi.araddr, 32'h1c000010);
    axi.arready = 1'b1;
    drv_edge();
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'h11111111;
    smp();
    chk1("ooo_inst_data_ok", inst_sram_data_ok, 1'b1);
    chk1("ooo_data_quiet", data_sram_data_ok, 1'b0);
    chk32("ooo_inst_rdata", inst_sram_rdata, 32'h11111111);
    drv_edge();
    axi.rid = 4'd1; axi.rdata = 32'h22222222;
    smp();
    chk1("ooo_data_data_ok", data_sram_data_ok, 1'b1);
    chk1("ooo_inst_quiet", inst_sram_data_ok, 1'b0);
    chk32("ooo_data_rdata", data_sram_rdata, 32'h22222222);
    drv_edge();
    axi.rvalid = 1'b0;

    // Store byte with awready three cycles ahead of wready, then a read blocked in WAIT_B.
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h1000;
    data_sram_size = 2'd0; data_sram_wstrb = 4'b0010; data_sram_wdata = 32'h0000ab00;
    smp();
    chk1("sb_addr_ok", data_sram_addr_ok, 1'b1);
    drv_edge();
    data_sram_req = 1'b0;
    smp();
    axi.awready = 1'b1;
    drv_edge();
    axi.awready = 1'b0;
    smp();
    chk1("sb_aw_dropped", axi.awvalid, 1'b0);
    chk1("sb_w_held", axi.wvalid, 1'b1);
    chk32("sb_wdata_stable", axi.wdata, 32'h0000ab00);
    drv_edge();
    smp();
    chk1("sb_w_held2", axi.wvalid, 1'b1);
    chk1("sb_no_early_ok", data_sram_data_ok, 1'b0);
    drv_edge();
    smp();
    axi.wready = 1'b1;
    drv_edge();
    axi.wready = 1'b0;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h50; data_sram_size = 2'd2;
    smp();
    chk1("sb_w_dropped", axi.wvalid, 1'b0);
    chk1("sb_wait_b_no_ok", data_sram_data_ok, 1'b0);
    chk1("rd_blocked_wait_b", data_sram_addr_ok, 1'b0);
    drv_edge();
    axi.bvalid = 1'b1;
    smp();
    chk1("sb_bvalid_ok", data_sram_data_ok, 1'b1);
    chk1("rd_blocked_on_b", data_sram_addr_ok, 1'b0);
    drv_edge();
    axi.bvalid = 1'b0;
    smp();
    chk1("rd_after_b", data_sram_addr_ok, 1'b1);
    drv_edge();
    data_sram_req = 1'b0;
    smp();
    chk32("rd_after_b_araddr", axi.araddr, 32'h50);
    axi.arready = 1'b1;
    drv_edge();
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rid = 4'd1; axi.rdata = 32'h0badf00d;
    smp();
    chk1("rd_after_b_data_ok", data_sram_data_ok, 1'b1);
    drv_edge();
    axi.rvalid = 1'b0;

    // Inst R and data B in the same cycle.
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000020;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h2000;
    data_sram_wstrb = 4'hf; data_sram_wdata = 32'h5a5a5a5a;
    smp();
    chk1("co_inst_addr_ok", inst_sram_addr_ok, 1'b1);
    chk1("co_data_addr_ok", data_sram_addr_ok, 1'b1);
    drv_edge();
    inst_sram_req = 1'b0; data_sram_req = 1'b0;
    smp();
    axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
    drv_edge();
    axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    drv_edge();
    axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'h33333333; axi.bvalid = 1'b1;
    smp();
    chk1("co_inst_data_ok", inst_sram_data_ok, 1'b1);
    chk1("co_data_data_ok", data_sram_data_ok, 1'b1);
    chk32("co_inst_rdata", inst_sram_rdata, 32'h33333333);
    drv_edge();
    axi.rvalid = 1'b0; axi.bvalid = 1'b0;

    // Reset while arvalid waits for arready; inst wr flag must be ignored.
    inst_sram_req = 1'b1; inst_sram_wr = 1'b1; inst_sram_addr = 32'h1c000030;
    smp();
    chk1("rst_mid_addr_ok", inst_sram_addr_ok, 1'b1);
    drv_edge();
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0;
    smp();
    chk1("rst_mid_arvalid", axi.arvalid, 1'b1);
    resetn = 1'b0;
    #1;
    chk1("rst_async_arvalid", axi.arvalid, 1'b0);
    drv_edge();
    drv_edge();
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk1($sformatf("post_rst_inst_data_ok%0d", k), inst_sram_data_ok, 1'b0);
      chk1($sformatf("post_rst_data_data_ok%0d", k), data_sram_data_ok, 1'b0);
      chk1($sformatf("post_rst_arvalid%0d", k), axi.arvalid, 1'b0);
      drv_edge();
    end
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000040;
    smp();
    chk1("post_rst_inst_accept", inst_sram_addr_ok, 1'b1);
    drv_edge();
    inst_sram_req = 1'b0;
    smp();
    chk32("post_rst_araddr", axi.araddr, 32'h1c000040);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
